// File: rtl/serial_bit_tx_pkg.sv
// serial_bit_tx_pkg - types and helpers shared by the serial transmitter.
//   state_e    : frame state, encoded from serial_defs.vh
//   cnt_width  : counter width for a count range, never below 1 bit
`timescale 1ns/1ps
package serial_bit_tx_pkg;

`include "serial_defs.vh"

   typedef enum logic [1:0] {
      StIdle  = S_IDLE,
      StStart = S_START,
      StData  = S_DATA,
      StStop  = S_STOP
   } state_e;

   // $clog2 of 1 is 0; a counter still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_bit_tx_if.sv
// serial_bit_tx_if - handshake and line bundle of the serial transmitter.
//   data  : frame payload, sampled on accept
//   load  : request to send data
//   ready : a load is accepted on this edge
//   busy  : a frame is on the line
//   done  : one-cycle pulse at frame end
//   txd   : serial line, idle high
// Modports: master (the sender of requests), slave (the transmitter).
`timescale 1ns/1ps
interface serial_bit_tx_if #(
   parameter int unsigned DATA_BITS = 8
) ();

   logic [DATA_BITS-1:0] data;
   logic                 load;
   logic                 ready;
   logic                 busy;
   logic                 done;
   logic                 txd;

   modport master (
      output data,
      output load,
      input  ready,
      input  busy,
      input  done,
      input  txd
   );

   modport slave (
      input  data,
      input  load,
      output ready,
      output busy,
      output done,
      output txd
   );

endinterface

// File: rtl/serial_bit_tx_bit_timer.sv
// serial_bit_tx_bit_timer - bit-cell timer for the serial transmitter.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   run  : count while high; held at zero while low
//   tick : high during the last cycle of each bit cell
`timescale 1ns/1ps
module serial_bit_tx_bit_timer
   import serial_bit_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int unsigned     CW   = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!run || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/serial_defs.vh
// serial_defs.vh - shared definitions for the serial transmitter slice.
// Holds the state encoding and the default bit-cell length. Included by
// serial_bit_tx_pkg. The guard keeps a second inclusion harmless.
`ifndef SERIAL_DEFS_VH
`define SERIAL_DEFS_VH

localparam logic [1:0] S_IDLE  = 2'd0;
localparam logic [1:0] S_START = 2'd1;
localparam logic [1:0] S_DATA  = 2'd2;
localparam logic [1:0] S_STOP  = 2'd3;

localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

`endif

// File: rtl/serial_bit_tx.sv
// serial_bit_tx - asynchronous-framed serial transmitter (board-level model).
// Sends start bit, DATA_BITS data bits LSB first, then STOP_BITS stop bits,
// each cell CLKS_PER_BIT clocks long. The line pin carries TTL-like rise and
// fall delays for simulation.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : serial_bit_tx_if slave (data, load, ready, busy, done, txd)
`timescale 1ns/1ps
module serial_bit_tx
   import serial_bit_tx_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned TPLH         = 25,
   parameter int unsigned TPHL         = 40
) (
   input logic            clk,
   input logic            rst,
   serial_bit_tx_if.slave bus
);

   localparam int unsigned   BW        = cnt_width(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic                 txd_q, txd_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 run;
   logic                 tick;

   assign run = (state_q != StIdle);

   serial_bit_tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk (clk),
      .rst (rst),
      .run (run),
      .tick(tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      txd_d     = txd_q;
      ready_d   = ready_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.load && ready_q) begin
               state_d   = StStart;
               shift_d   = bus.data;
               bit_cnt_d = '0;
               txd_d     = 1'b0;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
            end
         end
         StStart: begin
            if (tick) begin
               state_d   = StData;
               txd_d     = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
            end
         end
         StData: begin
            if (tick) begin
               if (bit_cnt_q == LAST_DATA) begin
                  state_d   = StStop;
                  txd_d     = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  txd_d     = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (tick) begin
               if (bit_cnt_q == LAST_STOP) begin
                  state_d   = StIdle;
                  bit_cnt_d = '0;
                  ready_d   = 1'b1;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         txd_q     <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         txd_q     <= txd_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

   // Line pin: one copy delayed by the rise time, one by the fall time.
   // Combining them picks the rise delay for 0->1 and the fall delay for 1->0;
   // a pulse shorter than the delay difference never reaches the pin.
   logic txd_lh;
   logic txd_hl;

   assign #(TPLH) txd_lh = txd_q;
   assign #(TPHL) txd_hl = txd_q;

   assign bus.txd = (TPHL >= TPLH) ? (txd_lh | txd_hl) : (txd_lh & txd_hl);

endmodule
